// File: rtl/axis_packet_capture.sv
// AXI-Stream packet sink: captures one packet into a word buffer and holds it
// for a random-access reader until pkt_release ('release' is a reserved word).
module axis_packet_capture #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic [KEEP_WIDTH-1:0] s_tkeep,
   input  logic                  s_tlast,
   output logic                  pkt_ready,
   output logic [ADDR_W:0]       pkt_len,
   output logic [KEEP_WIDTH-1:0] pkt_last_keep,
   output logic                  pkt_overflow,
   output logic                  pkt_keep_err,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  pkt_release,
   output logic [15:0]           pkt_count
);

   typedef enum logic [1:0] {RECV, DROP, HOLD} state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0]       wr_ptr_q;
   logic [ADDR_W:0]         pkt_len_q;
   logic [KEEP_WIDTH-1:0]   last_keep_q;
   logic                    overflow_q, keep_err_q;
   logic                    s_tready_q, pkt_ready_q;
   logic [15:0]             count_q, count_d;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    hs;

   assign hs      = s_tvalid && s_tready_q;
   assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RECV;
         s_tready_q  <= 1'b1;
         pkt_ready_q <= 1'b0;
         wr_ptr_q    <= '0;
         pkt_len_q   <= '0;
         last_keep_q <= '0;
         overflow_q  <= 1'b0;
         keep_err_q  <= 1'b0;
         count_q     <= '0;
      end else begin
         case (state_q)
            RECV: if (hs) begin
               wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
               if (s_tlast) begin
                  last_keep_q <= s_tkeep;
                  pkt_len_q   <= (ADDR_W+1)'(wr_ptr_q) + (ADDR_W+1)'(1);
                  count_q     <= count_d;
                  state_q     <= HOLD;
                  s_tready_q  <= 1'b0;
                  pkt_ready_q <= 1'b1;
               end else begin
                  if (!(&s_tkeep)) keep_err_q <= 1'b1;
                  // Last free slot filled without tlast: swallow the tail.
                  if (wr_ptr_q == ADDR_W'(DEPTH-1)) begin
                     overflow_q <= 1'b1;
                     pkt_len_q  <= (ADDR_W+1)'(DEPTH);
                     state_q    <= DROP;
                  end
               end
            end
            DROP: if (hs && s_tlast) begin
               last_keep_q <= s_tkeep;
               count_q     <= count_d;
               state_q     <= HOLD;
               s_tready_q  <= 1'b0;
               pkt_ready_q <= 1'b1;
            end
            default: if (pkt_release) begin
               wr_ptr_q    <= '0;
               pkt_len_q   <= '0;
               last_keep_q <= '0;
               overflow_q  <= 1'b0;
               keep_err_q  <= 1'b0;
               state_q     <= RECV;
               s_tready_q  <= 1'b1;
               pkt_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Buffer storage is intentionally left uninitialised across reset/release.
   always_ff @(posedge clk) begin
      if (state_q == RECV && hs) mem_q[wr_ptr_q] <= s_tdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= mem_q[rd_addr];
   end

   assign s_tready      = s_tready_q;
   assign pkt_ready     = pkt_ready_q;
   assign pkt_len       = pkt_len_q;
   assign pkt_last_keep = last_keep_q;
   assign pkt_overflow  = overflow_q;
   assign pkt_keep_err  = keep_err_q;
   assign rd_data       = rd_data_q;
   assign pkt_count     = count_q;

endmodule

// File: tb/tb_axis_packet_capture.sv
// Directed bench for axis_packet_capture (DATA_WIDTH=32, DEPTH=16).
module tb_axis_packet_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tkeep = '0;
   logic        s_tlast = 1'b0;
   logic        pkt_ready;
   logic [4:0]  pkt_len;
   logic [3:0]  pkt_last_keep;
   logic        pkt_overflow, pkt_keep_err;
   logic [3:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        pkt_release = 1'b0;
   logic [15:0] pkt_count;

   int n_cmp = 0;
   int n_err = 0;

   axis_packet_capture #(.DATA_WIDTH(32), .DEPTH(16)) dut (
      .clk(clk), .rst(rst),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .pkt_ready(pkt_ready), .pkt_len(pkt_len), .pkt_last_keep(pkt_last_keep),
      .pkt_overflow(pkt_overflow), .pkt_keep_err(pkt_keep_err),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .pkt_release(pkt_release), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and wait (bounded) for its handshake; returns cycles taken.
   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int cyc);
      bit done = 0;
      cyc = 0;
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
      for (int i = 0; i < 50 && !done; i++) begin
         done = s_tready;
         tick();
         cyc++;
      end
      if (!done) chk("hs_timeout", 0, 1);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      rd_addr = a;
      tick();
      chk(tag, rd_data, exp);
   endtask

   task automatic do_release();
      s_tvalid = 1'b0;
      pkt_release = 1'b1;
      tick();
      pkt_release = 1'b0;
   endtask

   initial begin
      int c, sum;
      logic [31:0] t1 [4];
      t1 = '{32'd1, 32'd0, 32'd0, 32'd0};

      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_tready", s_tready, 1);
      chk("rst_pkt_ready", pkt_ready, 0);
      chk("rst_len", pkt_len, 0);
      chk("rst_keep", pkt_last_keep, 0);
      chk("rst_ovf", pkt_overflow, 0);
      chk("rst_kerr", pkt_keep_err, 0);
      chk("rst_count", pkt_count, 0);
      chk("rst_rdata", rd_data, 0);

      // 4-beat packet, continuous valid
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         send(t1[i], 4'hF, i == 3, c);
         sum += c;
      end
      chk("t1_cycles", sum, 4);
      chk("t1_pkt_ready", pkt_ready, 1);
      chk("t1_tready", s_tready, 0);
      chk("t1_len", pkt_len, 4);
      chk("t1_keep", pkt_last_keep, 4'hF);
      chk("t1_count", pkt_count, 1);
      for (int i = 0; i < 4; i++) rd(4'(i), t1[i], "t1_rd");

      // Backpressure while holding
      s_tvalid = 1'b1; s_tdata = 32'd99; s_tlast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_tready", s_tready, 0);
      end
      chk("t2_hold_len", pkt_len, 4);
      do_release();
      chk("t2_rel_pkt_ready", pkt_ready, 0);
      chk("t2_rel_tready", s_tready, 1);
      chk("t2_rel_len", pkt_len, 0);
      send(32'd5, 4'hF, 1'b0, c);
      send(32'd6, 4'hF, 1'b1, c);
      chk("t2_len", pkt_len, 2);
      chk("t2_count", pkt_count, 2);
      rd(4'd1, 32'd6, "t2_rd1");
      rd(4'd0, 32'd5, "t2_rd0");
      do_release();

      // Overflow: 20 beats into a 16-word buffer
      sum = 0;
      for (int i = 0; i < 20; i++) begin
         send(32'(i), 4'hF, i == 19, c);
         sum += c;
      end
      chk("t3_cycles", sum, 20);
      chk("t3_ovf", pkt_overflow, 1);
      chk("t3_len", pkt_len, 16);
      chk("t3_count", pkt_count, 3);
      chk("t3_pkt_ready", pkt_ready, 1);
      for (int i = 0; i < 16; i++) rd(4'(i), 32'(i), "t3_rd");
      do_release();
      chk("t3_ovf_clr", pkt_overflow, 0);

      // Keep handling
      send(32'd10, 4'hF, 1'b0, c);
      send(32'd11, 4'h3, 1'b0, c);
      send(32'd12, 4'h1, 1'b1, c);
      chk("t4_kerr", pkt_keep_err, 1);
      chk("t4_keep", pkt_last_keep, 4'h1);
      chk("t4_len", pkt_len, 3);
      chk("t4_count", pkt_count, 4);
      do_release();
      chk("t4_kerr_clr", pkt_keep_err, 0);
      chk("t4_keep_clr", pkt_last_keep, 0);

      // Reset mid-packet
      send(32'd20, 4'hF, 1'b0, c);
      send(32'd21, 4'hF, 1'b0, c);
      s_tvalid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_tready", s_tready, 1);
      chk("t5_pkt_ready", pkt_ready, 0);
      chk("t5_len", pkt_len, 0);
      chk("t5_count", pkt_count, 0);
      chk("t5_flags", {pkt_overflow, pkt_keep_err, pkt_last_keep}, 0);
      chk("t5_rdata", rd_data, 0);
      send(32'd9, 4'hF, 1'b1, c);
      chk("t5_len1", pkt_len, 1);
      chk("t5_count1", pkt_count, 1);
      rd(4'd0, 32'd9, "t5_rd0");
      do_release();

      // Spurious release in RECV, gapped valid
      pkt_release = 1'b1;
      tick();
      pkt_release = 1'b0;
      chk("t6_sp_tready", s_tready, 1);
      chk("t6_sp_pkt_ready", pkt_ready, 0);
      for (int i = 0; i < 4; i++) begin
         send(32'd30 + 32'(i), 4'hF, i == 3, c);
         if (i == 0) begin
            pkt_release = 1'b1; s_tvalid = 1'b0;
            tick();
            pkt_release = 1'b0;
         end else if (i < 3) begin
            s_tvalid = 1'b0;
            tick();
         end
      end
      s_tvalid = 1'b0;
      chk("t6_len", pkt_len, 4);
      chk("t6_count", pkt_count, 2);
      chk("t6_pkt_ready", pkt_ready, 1);
      for (int i = 0; i < 4; i++) rd(4'(i), 32'd30 + 32'(i), "t6_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
